random_spawner: RTL and testbench
=================================

Name: random_spawner

Overview:
- Downstream consumer of the 8-bit LFSR random generator.
- Samples the current random byte and turns it into timed spawn events for the game logic: lane/column, speed class, and the random delay before the next spawn.
- Drives the generator's enable input so that the LFSR advances exactly once per accepted spawn.
- Hands each event to the drawing/game FSM over a valid/ready handshake.

Parameters:
- TICK_DIV, 833333: clock cycles per game tick (60 Hz at 50 MHz); must be >= 2.
- MIN_GAP, 8: minimum number of ticks between an accepted spawn and the next draw; must be >= 1.
- GAP_MASK, 5'h1F: mask applied to the random gap field.
- NUM_COLS, 5: number of spawn columns; legal range 4..8.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; high = spawning enabled.
- rnd_in  in  8  current LFSR output.
- rng_enable  out  1  one-cycle pulse that advances the LFSR.
- spawn_valid  out  1  spawn event offered.
- spawn_ready  in  1  consumer accepts the event.
- spawn_col  out  3  column index, 0..NUM_COLS-1.
- spawn_speed  out  2  speed class, 0..3.
- spawn_count  out  8  number of accepted spawns, wraps 255->0.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clock. While reset==0 at a rising edge:
  - state <= IDLE.
  - rng_enable, spawn_valid, spawn_col, spawn_speed and spawn_count all <= 0.
  - tick counter and gap counter <= 0.
  - Reset overrides everything, including mid-handshake and mid-WAIT.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for the single cycle in which the counter equals TICK_DIV-1.
  - The counter is held at 0 while in IDLE.
- Field extraction from rnd_in, sampled only in DRAW:
  - r = rnd_in[2:0]; spawn_col = (r < NUM_COLS) ? r : r - NUM_COLS.
  - spawn_speed = rnd_in[4:3].
  - gap = MIN_GAP + (rnd_in[7:3] & GAP_MASK), computed without overflow in a counter of at least 6 bits.
- FSM states:
  - IDLE: outputs quiescent. Go to DRAW on the first edge with start==1.
  - DRAW: lasts exactly one cycle. On its exit edge, register spawn_col, spawn_speed and gap_cnt<=gap, then go to OFFER. If start==0 during DRAW, go to IDLE and register nothing.
  - OFFER:
    - spawn_valid==1.
    - spawn_col and spawn_speed stay stable until the handshake.
    - Handshake = rising edge with spawn_valid && spawn_ready.
    - On the handshake: spawn_count += 1, rng_enable <= 1 for exactly the next cycle, then go to WAIT if start==1, else IDLE.
    - start falling while in OFFER does not withdraw the offer; the handshake completes first.
  - WAIT:
    - spawn_valid==0; rng_enable is low except for the pulse in the first cycle after the handshake.
    - On each tick: if gap_cnt==1 go to DRAW, else gap_cnt -= 1.
    - If start==0, go to IDLE on the next edge.
- Latency:
  - start rising edge -> DRAW in the next cycle -> spawn_valid high 2 cycles after start is sampled.
  - The LFSR updates at the edge that ends the rng_enable pulse, so the next DRAW always sees a fresh byte.
- spawn_col never reaches NUM_COLS or above for any rnd_in value.
- Once registered, spawn_col and spawn_speed hold their values until the next DRAW or reset.

Test Plan:
All scenarios use TICK_DIV=4, MIN_GAP=2, GAP_MASK=5'h03, NUM_COLS=5.
1. Reset: hold reset=0 for 3 cycles with start=1 -> all outputs 0 and state IDLE; release -> DRAW on the first edge with start==1.
2. First spawn: rnd_in=8'h0F, start=1, spawn_ready=1 -> spawn_valid=1 two cycles after start is sampled, with spawn_col=2 and spawn_speed=1. One cycle later rng_enable=1 for one cycle and spawn_count=1. Gap = 2+1 = 3 ticks, so the next spawn_valid follows 3 ticks (12 cycles, ±1 tick phase) plus DRAW.
3. Backpressure: spawn_ready=0 for 10 cycles while in OFFER -> spawn_valid stays 1, col/speed unchanged, rng_enable=0, spawn_count unchanged. Raise ready -> exactly one accept and one rng_enable pulse.
4. Column folding: sweep rnd_in[2:0] over 0..7 across draws -> spawn_col sequence 0,1,2,3,4,0,1,2. Any value >= 5 is an error.
5. Stop and reset:
   - start=0 during OFFER -> handshake completes, then IDLE, with no further spawn_valid.
   - reset=0 in mid-WAIT -> all outputs 0 on the next edge.
6. Count wrap: 256 consecutive handshakes -> spawn_count returns to 0, with exactly 256 rng_enable pulses.

Source files
------------

// File: rtl/random_spawner_if.sv
// Spawn event handshake between the random spawner and the game FSM.
// master: spawner drives valid/col/speed/count; slave: consumer drives ready.
interface random_spawner_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [2:0] spawn_col;
    logic [1:0] spawn_speed;
    logic [7:0] spawn_count;

    modport master (
        output spawn_valid,
        output spawn_col,
        output spawn_speed,
        output spawn_count,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_col,
        input  spawn_speed,
        input  spawn_count,
        output spawn_ready
    );
endinterface

// File: rtl/random_spawner.sv
// Turns LFSR bytes into timed spawn events (column, speed, gap) and
// advances the LFSR once per accepted event.
// Ports: clock, reset (sync, active-low), start (enable level),
//   rnd_in (LFSR byte), rng_enable (LFSR advance pulse),
//   spawn (valid/ready event bus: col, speed, accepted count).
module random_spawner #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned MIN_GAP  = 8,
    parameter logic [4:0]  GAP_MASK = 5'h1F,
    parameter int unsigned NUM_COLS = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rnd_in,
    output logic             rng_enable,
    random_spawner_if.master spawn
);

    localparam int TW = $clog2(TICK_DIV);
    // Wide enough for MIN_GAP plus the largest 5-bit gap field.
    localparam int GW = $clog2(MIN_GAP + 32);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]    NC4       = 4'(NUM_COLS);
    localparam logic [2:0]    NC3       = NC4[2:0];
    localparam logic [GW-1:0] GAP_BASE  = GW'(MIN_GAP);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        OFFER,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    col_q;
    logic [1:0]    speed_q;
    logic [7:0]    count_q;
    logic          rng_q;

    logic          capture;
    logic          accept;
    logic          gap_step;

    logic [2:0]    col_raw;
    logic [2:0]    col_fold;
    logic [4:0]    gap_field;
    logic [GW-1:0] gap_val;

    assign tick = (tick_cnt == TICK_LAST);

    // A 3-bit value is below 2*NUM_COLS for every legal NUM_COLS,
    // so one conditional subtract folds it into range.
    always_comb begin
        col_raw  = rnd_in[2:0];
        col_fold = col_raw;
        if ({1'b0, col_raw} >= NC4) begin
            col_fold = col_raw - NC3;
        end
    end

    assign gap_field = rnd_in[7:3] & GAP_MASK;
    assign gap_val   = GAP_BASE + GW'(gap_field);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        gap_step   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = OFFER;
                end else begin
                    state_next = IDLE;
                end
            end
            OFFER: begin
                // A dropped start does not withdraw a pending offer.
                if (spawn.spawn_ready) begin
                    accept     = 1'b1;
                    state_next = start ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (!start) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (gap_cnt == GAP_ONE) begin
                        state_next = DRAW;
                    end else begin
                        gap_step = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_cnt <= '0;
            gap_cnt  <= '0;
            col_q    <= '0;
            speed_q  <= '0;
            count_q  <= '0;
            rng_q    <= 1'b0;
        end else begin
            // Tick phase restarts from zero whenever spawning resumes.
            if (state == IDLE || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            // LFSR steps at the edge ending this pulse, ahead of next DRAW.
            rng_q <= accept;

            if (accept) begin
                count_q <= count_q + 8'd1;
            end

            if (capture) begin
                col_q   <= col_fold;
                speed_q <= rnd_in[4:3];
                gap_cnt <= gap_val;
            end else if (gap_step) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
        end
    end

    assign rng_enable        = rng_q;
    assign spawn.spawn_valid = (state == OFFER);
    assign spawn.spawn_col   = col_q;
    assign spawn.spawn_speed = speed_q;
    assign spawn.spawn_count = count_q;

endmodule

// File: tb/tb_random_spawner.sv
// Directed bench for random_spawner with small tick/gap parameters.
// Expected values are hand-derived from the rnd_in bytes applied.
module tb_random_spawner;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MIN_GAP  = 2;
    localparam logic [4:0]  GAP_MASK = 5'h03;
    localparam int unsigned NUM_COLS = 5;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] rnd_in = 8'h00;
    logic       rng_enable;

    int         checks     = 0;
    int         failures   = 0;
    int         rng_pulses = 0;
    logic [7:0] exp_count  = 8'd0;

    random_spawner_if sif ();

    random_spawner #(
        .TICK_DIV(TICK_DIV),
        .MIN_GAP (MIN_GAP),
        .GAP_MASK(GAP_MASK),
        .NUM_COLS(NUM_COLS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rnd_in    (rnd_in),
        .rng_enable(rng_enable),
        .spawn     (sif)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rng_enable) begin
            rng_pulses <= rng_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!sif.spawn_valid && cyc < 200) begin
            step(1);
            cyc++;
        end
    endtask

    // One full spawn with ready high: wait for the offer, check the
    // fields, take the handshake and check count plus LFSR pulse.
    task automatic do_spawn(input logic [7:0] rnd, input int ecol,
                            input int espd);
        int cyc;
        rnd_in = rnd;
        wait_valid(cyc);
        check("spawn_seen", 32'(sif.spawn_valid), 32'd1);
        check("col", 32'(sif.spawn_col), 32'(ecol));
        check("col_range", 32'(sif.spawn_col < 3'(NUM_COLS)), 32'd1);
        check("speed", 32'(sif.spawn_speed), 32'(espd));
        step(1);
        exp_count = exp_count + 8'd1;
        check("count", 32'(sif.spawn_count), 32'(exp_count));
        check("rng_pulse", 32'(rng_enable), 32'd1);
    endtask

    int col_exp [8] = '{0, 1, 2, 3, 4, 0, 1, 2};

    initial begin
        int cyc;
        int p0;
        bit seen;

        // Reset held with start high: everything quiescent.
        sif.spawn_ready = 1'b1;
        start  = 1'b1;
        rnd_in = 8'h0F;
        reset  = 1'b0;
        step(3);
        check("rst_valid", 32'(sif.spawn_valid), 32'd0);
        check("rst_rng", 32'(rng_enable), 32'd0);
        check("rst_col", 32'(sif.spawn_col), 32'd0);
        check("rst_speed", 32'(sif.spawn_speed), 32'd0);
        check("rst_count", 32'(sif.spawn_count), 32'd0);

        // First spawn: 0x0F -> col 7-5=2, speed 1, gap 2+1=3 ticks.
        reset = 1'b1;
        step(1);
        check("draw_no_valid", 32'(sif.spawn_valid), 32'd0);
        step(1);
        check("first_valid", 32'(sif.spawn_valid), 32'd1);
        check("first_col", 32'(sif.spawn_col), 32'd2);
        check("first_speed", 32'(sif.spawn_speed), 32'd1);
        check("first_rng_low", 32'(rng_enable), 32'd0);
        step(1);
        exp_count = 8'd1;
        check("first_count", 32'(sif.spawn_count), 32'd1);
        check("first_rng", 32'(rng_enable), 32'd1);
        check("first_taken", 32'(sif.spawn_valid), 32'd0);

        // Next byte 0xB5 -> col 5-5=0, speed 2, gap 2+2=4.
        sif.spawn_ready = 1'b0;
        rnd_in = 8'hB5;
        step(1);
        check("rng_one_cycle", 32'(rng_enable), 32'd0);
        // Tick phase is fixed: counter restarted at DRAW, so 3 ticks
        // land 11 edges after the handshake, one of them already taken.
        wait_valid(cyc);
        check("gap_latency", 32'(cyc), 32'd10);
        check("bp_col", 32'(sif.spawn_col), 32'd0);
        check("bp_speed", 32'(sif.spawn_speed), 32'd2);

        // Backpressure: changing rnd_in must not disturb the offer.
        rnd_in = 8'h1B;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bp_valid", 32'(sif.spawn_valid), 32'd1);
            check("bp_hold_col", 32'(sif.spawn_col), 32'd0);
            check("bp_hold_spd", 32'(sif.spawn_speed), 32'd2);
            check("bp_rng", 32'(rng_enable), 32'd0);
            check("bp_count", 32'(sif.spawn_count), 32'd1);
        end
        p0 = rng_pulses;
        sif.spawn_ready = 1'b1;
        step(1);
        exp_count = 8'd2;
        check("bp_accept", 32'(sif.spawn_count), 32'd2);
        check("bp_rng_hi", 32'(rng_enable), 32'd1);
        step(1);
        check("bp_rng_lo", 32'(rng_enable), 32'd0);
        check("bp_one_pulse", 32'(rng_pulses - p0), 32'd1);

        // Column folding sweep, speed 0, minimum gap.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] r;
            r = 8'(i);
            do_spawn(r, col_exp[i], 0);
        end

        // Stop during OFFER: handshake still completes, then silence.
        sif.spawn_ready = 1'b0;
        rnd_in = 8'h00;
        wait_valid(cyc);
        check("stop_offer", 32'(sif.spawn_valid), 32'd1);
        start = 1'b0;
        step(3);
        check("stop_held", 32'(sif.spawn_valid), 32'd1);
        sif.spawn_ready = 1'b1;
        step(1);
        exp_count = exp_count + 8'd1;
        check("stop_count", 32'(sif.spawn_count), 32'(exp_count));
        check("stop_rng", 32'(rng_enable), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sif.spawn_valid || rng_enable) seen = 1'b1;
        end
        check("stop_quiet", 32'(seen), 32'd0);

        // Reset in mid-WAIT: 0x13 -> col 3, speed 2, gap 4.
        start = 1'b1;
        do_spawn(8'h13, 3, 2);
        step(3);
        reset = 1'b0;
        step(1);
        check("wrst_valid", 32'(sif.spawn_valid), 32'd0);
        check("wrst_rng", 32'(rng_enable), 32'd0);
        check("wrst_col", 32'(sif.spawn_col), 32'd0);
        check("wrst_speed", 32'(sif.spawn_speed), 32'd0);
        check("wrst_count", 32'(sif.spawn_count), 32'd0);
        reset = 1'b1;
        exp_count = 8'd0;

        // 256 handshakes wrap the count back to zero.
        p0 = rng_pulses;
        for (int i = 0; i < 256; i++) begin
            do_spawn(8'h06, 1, 0);
        end
        step(2);
        check("wrap_count", 32'(sif.spawn_count), 32'd0);
        check("wrap_pulses", 32'(rng_pulses - p0), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
